// File: rtl/keypad_entry_if.sv
// Keypad pins plus the digit strobe bundle: keypad_entry is the master, the board/lock side the slave.
interface keypad_entry_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       trigger;
  logic [3:0] digit;
  logic       key_held;
  logic       timeout;

  modport master (input col, output row, trigger, digit, key_held, timeout);
  modport slave  (output col, input row, trigger, digit, key_held, timeout);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner, press/release debouncer and {row,col} digit encoder.
// Define ENTRY_TIMEOUT_EN to build the post-digit inactivity timeout pulse.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 20000,
  parameter int unsigned TIMEOUT  = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  keypad_entry_if.master kp_if
);

  localparam int unsigned MAX_SD = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int unsigned MAX_P  = (MAX_SD > TIMEOUT) ? MAX_SD : TIMEOUT;
  localparam int          CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  // colS lags a row change by the row flop plus the synchroniser; ignore it until it reflects the new row
  localparam logic [CNT_W-1:0] SETTLE    = (SCAN_DIV > 2) ? CNT_W'(2) : CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_SCAN      = 3'd0;
  localparam logic [2:0] S_DEB_PRESS = 3'd1;
  localparam logic [2:0] S_PRESSED   = 3'd2;
  localparam logic [2:0] S_REJECT    = 3'd3;
  localparam logic [2:0] S_WAIT_REL  = 3'd4;
  localparam logic [2:0] S_DEB_REL   = 3'd5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  function automatic logic one_low(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, ~c[i]};
    return (n == 3'd1);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic [3:0]       col_meta_q, col_sync_q;
  logic [2:0]       state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             trigger_q, trigger_d;
  logic [3:0]       digit_q, digit_d;
  logic             key_held_q, key_held_d;

  // Scan / debounce FSM next-state and output decode
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    pat_d      = pat_q;
    row_idx_d  = row_idx_q;
    digit_d    = digit_q;
    key_held_d = key_held_q;
    trigger_d  = 1'b0;
    case (state_q)
      S_SCAN: begin
        if ((col_sync_q != 4'hF) && (scan_cnt_q >= SETTLE)) begin
          pat_d      = col_sync_q;
          row_idx_d  = low_idx(row_q);
          deb_cnt_d  = CNT_ONE;
          scan_cnt_d = CNT_ZERO;
          state_d    = S_DEB_PRESS;
        end else if (scan_cnt_q >= SCAN_LAST) begin
          row_d      = {row_q[2:0], row_q[3]};
          scan_cnt_d = CNT_ZERO;
        end else begin
          scan_cnt_d = sat_inc(scan_cnt_q);
        end
      end
      S_DEB_PRESS: begin
        if (col_sync_q != pat_q) begin
          deb_cnt_d = CNT_ZERO;
          state_d   = S_SCAN;
        end else if (deb_cnt_q >= DEB_LAST) begin
          deb_cnt_d = CNT_ZERO;
          if (one_low(pat_q)) begin
            state_d    = S_PRESSED;
            trigger_d  = 1'b1;
            digit_d    = {row_idx_q, low_idx(pat_q)};
            key_held_d = 1'b1;
          end else begin
            state_d    = S_REJECT;
          end
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      S_PRESSED: begin
        state_d = S_WAIT_REL;
      end
      S_REJECT: begin
        key_held_d = 1'b0;
        state_d    = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (col_sync_q == 4'hF) begin
          deb_cnt_d = CNT_ONE;
          state_d   = S_DEB_REL;
        end else begin
          deb_cnt_d = CNT_ZERO;
        end
      end
      S_DEB_REL: begin
        if (col_sync_q != 4'hF) begin
          deb_cnt_d = CNT_ZERO;
          state_d   = S_WAIT_REL;
        end else if (deb_cnt_q >= DEB_LAST) begin
          deb_cnt_d  = CNT_ZERO;
          key_held_d = 1'b0;
          row_d      = {row_q[2:0], row_q[3]};
          scan_cnt_d = CNT_ZERO;
          state_d    = S_SCAN;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: begin
        state_d    = S_SCAN;
        row_d      = 4'b1110;
        scan_cnt_d = CNT_ZERO;
        deb_cnt_d  = CNT_ZERO;
        key_held_d = 1'b0;
      end
    endcase
  end

  // Column synchroniser, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      state_q    <= S_SCAN;
      row_q      <= 4'b1110;
      scan_cnt_q <= CNT_ZERO;
      deb_cnt_q  <= CNT_ZERO;
      pat_q      <= 4'hF;
      row_idx_q  <= 2'd0;
      trigger_q  <= 1'b0;
      digit_q    <= 4'h0;
      key_held_q <= 1'b0;
    end else begin
      col_meta_q <= kp_if.col;
      col_sync_q <= col_meta_q;
      state_q    <= state_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      pat_q      <= pat_d;
      row_idx_q  <= row_idx_d;
      trigger_q  <= trigger_d;
      digit_q    <= digit_d;
      key_held_q <= key_held_d;
    end
  end

  assign kp_if.row      = row_q;
  assign kp_if.trigger  = trigger_q;
  assign kp_if.digit    = digit_q;
  assign kp_if.key_held = key_held_q;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             armed_q, armed_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_q, timeout_d;

  // Idle timer: a new digit re-arms and takes priority over expiry in the same cycle
  always_comb begin
    armed_d    = armed_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    if (trigger_d) begin
      armed_d    = 1'b1;
      idle_cnt_d = CNT_ZERO;
    end else if (armed_q) begin
      if (idle_cnt_q >= TO_LAST) begin
        timeout_d  = 1'b1;
        armed_d    = 1'b0;
        idle_cnt_d = CNT_ZERO;
      end else begin
        idle_cnt_d = sat_inc(idle_cnt_q);
      end
    end else begin
      idle_cnt_d = CNT_ZERO;
    end
  end

  // Idle timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      idle_cnt_q <= CNT_ZERO;
      timeout_q  <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign kp_if.timeout = timeout_q;
`else
  assign kp_if.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Randomised keypad bench: stimulus queues expected digits, a negedge monitor checks triggers and timeouts.
module tb_keypad_entry;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int TIMEOUT  = 100;
  localparam int LAT_MAX  = 4*SCAN_DIV + 2 + DEBOUNCE + 1;
  localparam int REL_LAT  = DEBOUNCE + 2;
`ifdef ENTRY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys;
  logic [3:0]  col_s;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          trig_cnt = 0;
  int          trig_cyc = 0;
  int          to_seen = 0;
  int          last_trig = 0;
  bit          armed_m = 1'b0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  keypad_entry_if kp_if();

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp_if (kp_if)
  );

  // Passive key matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col_s = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kp_if.row[r] && keys[r*4+c]) col_s[c] = 1'b0;
  end
  assign kp_if.col = col_s;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: digit scoreboard plus an idle-time reference for the timeout pulse
  always @(negedge clk) begin : mon
    logic [3:0] e;
    bit         exp_to;
    if (!rst_n) begin
      armed_m = 1'b0;
    end else begin
      if (kp_if.trigger) begin
        trig_cnt++;
        trig_cyc  = cyc;
        armed_m   = 1'b1;
        last_trig = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trigger: got digit %h, expected no trigger (cycle %0d)", kp_if.digit, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kp_if.digit !== e) begin
            errors++;
            $display("FAIL digit: got %h expected %h (cycle %0d)", kp_if.digit, e, cyc);
          end
        end
      end
      exp_to = TO_EN && armed_m && !kp_if.trigger && ((cyc - last_trig) == TIMEOUT);
      if (exp_to) armed_m = 1'b0;
      if (kp_if.timeout || exp_to) begin
        checks++;
        if (kp_if.timeout !== exp_to) begin
          errors++;
          $display("FAIL timeout_pulse: got %b expected %b (cycle %0d)", kp_if.timeout, exp_to, cyc);
        end
      end
      if (kp_if.timeout) to_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic press_key(input int r, input int c);
    int start;
    int t0;
    int lat;
    exp_q.push_back(4'(r*4 + c));
    start = trig_cnt;
    keys  = 16'h0001 << (r*4 + c);
    t0    = cyc;
    for (int i = 0; i < LAT_MAX + 4; i++) begin
      if (trig_cnt != start) break;
      tick(1);
    end
    checks++;
    if (trig_cnt == start) begin
      errors++;
      $display("FAIL press_trigger: no trigger for key %0d within %0d cycles", r*4 + c, LAT_MAX + 4);
    end else begin
      lat = trig_cyc - t0;
      if (lat > LAT_MAX || lat < DEBOUNCE) begin
        errors++;
        $display("FAIL press_latency: got %0d cycles expected %0d..%0d", lat, DEBOUNCE, LAT_MAX);
      end
    end
  endtask

  task automatic release_key();
    int t0;
    keys = 16'h0000;
    t0   = cyc;
    for (int i = 0; i < REL_LAT + 6; i++) begin
      tick(1);
      if (kp_if.key_held === 1'b0) break;
    end
    chk("release_latency", 32'(cyc - t0), 32'(REL_LAT));
  endtask

  initial begin
    int bad;
    int base;
    int r;
    int c;
    keys  = 16'h0000;
    rst_n = 1'b0;
    tick(2);
    chk("reset_row", 32'(kp_if.row), 32'd14);
    chk("reset_trigger", 32'(kp_if.trigger), 32'd0);
    chk("reset_digit", 32'(kp_if.digit), 32'd0);
    chk("reset_key_held", 32'(kp_if.key_held), 32'd0);
    chk("reset_timeout", 32'(kp_if.timeout), 32'd0);
    rst_n = 1'b1;
    tick(7);

    // Steady row2/col1 press gives digit 9, then async reset while it is held
    press_key(2, 1);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_row", 32'(kp_if.row), 32'd14);
    chk("midrst_trigger", 32'(kp_if.trigger), 32'd0);
    chk("midrst_digit", 32'(kp_if.digit), 32'd0);
    chk("midrst_key_held", 32'(kp_if.key_held), 32'd0);
    keys = 16'h0000;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Reset while a key is still being debounced: that key must never trigger
    keys = 16'h0001 << (1*4 + 2);
    tick(6);
    #3 rst_n = 1'b0;
    keys = 16'h0000;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    chk("interrupted_key_held", 32'(kp_if.key_held), 32'd0);

    // Contact bounce on row2/col1 for 30 cycles, then a steady press
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? (16'h0001 << 9) : 16'h0000;
      tick(3);
    end
    press_key(2, 1);
    release_key();
    tick(10);

    // Two keys on row0 are rejected; scanning resumes once both are released
    keys = 16'h0009;
    tick(40);
    chk("double_key_held", 32'(kp_if.key_held), 32'd0);
    chk("double_row_frozen", 32'(kp_if.row), 32'd14);
    base = cyc;
    keys = 16'h0000;
    for (int i = 0; i < REL_LAT + 6; i++) begin
      tick(1);
      if (kp_if.row !== 4'b1110) break;
    end
    chk("double_resume_latency", 32'(cyc - base), 32'(REL_LAT));
    tick(10);

    // Long hold: one trigger, key_held stays high throughout
    r = int'($urandom_range(3, 0));
    c = int'($urandom_range(3, 0));
    press_key(r, c);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (kp_if.key_held !== 1'b1) bad++;
    end
    chk("hold_500_key_held_drops", 32'(bad), 32'd0);
    release_key();

    // Random keys with random gaps and hold times
    for (int k = 0; k < 10; k++) begin
      tick(int'($urandom_range(20, 1)));
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      press_key(r, c);
      tick(int'($urandom_range(10, 0)));
      release_key();
    end
    tick(TIMEOUT + 30);

    // Idle after a digit: exactly one timeout pulse
    base = to_seen;
    press_key(3, 0);
    release_key();
    tick(TIMEOUT + 30);
    chk("idle_timeout_count", 32'(to_seen - base), TO_EN ? 32'd1 : 32'd0);

    // A new digit inside the window restarts it: only the later digit times out
    press_key(0, 3);
    release_key();
    base = to_seen;
    tick(trig_cyc + 60 - cyc);
    press_key(1, 1);
    chk("restart_no_early_timeout", 32'(to_seen - base), 32'd0);
    release_key();
    tick(TIMEOUT + 30);
    chk("restart_timeout_count", 32'(to_seen - base), TO_EN ? 32'd1 : 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1000000 time units");
    $fatal(1);
  end
endmodule
